demux2_4: RTL and testbench
===========================

Name: demux2_4

Overview:
- Registered 1-to-2 demultiplexer for 4-bit words; the inverse of the 2:1 mux2_4 path.
- Accepts one input stream with a per-word route select and steers each word into channel A (in_sel=1) or channel B (in_sel=0).
- Each channel has its own small FIFO with a valid/ready output, so one stalled consumer does not lose data.
- Sits downstream of any mux2_4-style merge point to split the traffic back out.

Parameters:
- WIDTH, 4, data word width in bits.
- DEPTH, 4, entries per channel FIFO; power of two, >= 2.
- LVL_W, $clog2(DEPTH+1), width of the occupancy outputs (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- in_data  input  WIDTH  word to route.
- in_sel  input  1  route select: 1 -> channel A, 0 -> channel B.
- in_valid  input  1  in_data/in_sel valid.
- in_ready  output  1  word accepted at the next edge if in_valid.
- a_data  output  WIDTH  channel A head word.
- a_valid  output  1  channel A non-empty.
- a_ready  input  1  channel A consumer takes the head word.
- b_data  output  WIDTH  channel B head word.
- b_valid  output  1  channel B non-empty.
- b_ready  input  1  channel B consumer takes the head word.
- a_level  output  LVL_W  channel A occupancy, 0..DEPTH.
- b_level  output  LVL_W  channel B occupancy, 0..DEPTH.

Behaviour:
- Reset (async assert, synchronous-to-clk release):
  - Both FIFOs empty; read/write pointers 0; a_level = b_level = 0.
  - a_valid = b_valid = 0; a_data = b_data = 0.
  - in_ready is then 1.
  - Asserting rst mid-operation discards all stored words immediately, without waiting for a clock edge.
- in_ready is combinational: in_sel ? !a_full : !b_full.
  - It does not look at same-cycle pops: a full channel refuses a push even while it is being popped.
  - in_ready depends on in_sel, so the source must hold in_data and in_sel stable while in_valid=1 and in_ready=0.
- Push: at a rising edge with in_valid & in_ready, in_data is written to the selected FIFO at its wptr, and that wptr advances by 1 mod DEPTH.
- Output timing (show-ahead):
  - x_valid = (x_level != 0).
  - x_data = entry at rptr when valid, 0 when empty.
- Pop: at a rising edge with x_valid & x_ready, rptr advances by 1 mod DEPTH.
  - x_ready while x_valid=0 is ignored.
- Latency: a word pushed at edge N appears on x_data/x_valid in the cycle after edge N. There is no same-cycle bypass from input to output.
- Level update per edge: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
  - Simultaneous push and pop is possible only when the level is between 1 and DEPTH-1.
- Channels are fully independent. A push to A and a pop from B in the same cycle are both honoured.
- Ordering: per-channel FIFO order is preserved. There is no ordering relation between A and B.
- Wrap-around: pointers are log2(DEPTH) bits and wrap naturally. full = (level == DEPTH); empty = (level == 0).
- No overflow or underflow is possible by construction, and there are no error outputs.

Decomposition:
- Shared package demux_pkg:
  - default WIDTH and DEPTH;
  - localparam CH_A = 1'b1 and CH_B = 1'b0 (select encodings, matching mux2_4 sel polarity).
- One sub-module, demux_fifo: a synchronous show-ahead FIFO with push, pop, full, empty, level and head data, parameterised by WIDTH and DEPTH.
  - demux2_4 instantiates it twice and adds only the steering logic and the in_ready mux.

Test Plan:
- Reset values: rst=1 with random inputs -> a_valid=b_valid=0, a_data=b_data=0, levels=0, in_ready=1; then release rst.
- Routing: push 1111 (sel=1), 0000 (sel=0), 1110 (sel=1), 0001 (sel=0) with a_ready=b_ready=0.
  - Expect a_level=2 with a_data=1111, and b_level=2 with b_data=0000.
  - Then pop each channel -> A yields 1111 then 1110; B yields 0000 then 0001.
- Full and backpressure: push 4 words with sel=0 and b_ready=0 -> b_level=4 and in_ready=0 for sel=0.
  - Switching to sel=1 gives in_ready=1, and a push to A succeeds while B stays full.
  - A push to B in the same cycle as the first B pop is refused; it is accepted one cycle later.
- Simultaneous push/pop: B at level 2 with in_valid=1, sel=0, b_ready=1 for 6 cycles -> b_level stays 2, and output order matches input order.
- Wrap-around: 10 words pushed to A with interleaved pops (level never exceeds 3) -> all 10 emerge in order (1101, 1100, ...), and the pointers wrap twice.
- Async reset mid-stream: assert rst between edges with a_level=3 -> a_valid falls within the same cycle without a clock edge; after release, a_level=0 and the first new push appears correctly.

Source files
------------

// File: rtl/demux_pkg.sv
// demux_pkg
//   Shared definitions for the demux2_4 slice: default word width and
//   per-channel FIFO depth, plus the route-select encodings. The select
//   polarity matches the upstream mux2_4 (sel=1 picks A, sel=0 picks B).
package demux_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_DEPTH = 4;

    localparam logic CH_A = 1'b1;
    localparam logic CH_B = 1'b0;

endpackage : demux_pkg

// File: rtl/demux_fifo.sv
// demux_fifo
//   Synchronous show-ahead FIFO used for each demux output channel.
//   The head word is visible combinationally while the FIFO is non-empty
//   and reads as zero when empty.
// Ports
//   clk, rst    rising-edge clock, async active-high reset
//   push        write push_data at the next edge (ignored when full)
//   push_data   word to store
//   pop         drop the head word at the next edge (ignored when empty)
//   full        level == DEPTH
//   empty       level == 0
//   level       occupancy, 0..DEPTH
//   head_data   entry at the read pointer, 0 when empty
import demux_pkg::*;

module demux_fifo #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic [WIDTH-1:0]               push_data,
    input  logic                           pop,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     level,
    output logic [WIDTH-1:0]               head_data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic             push_en;
    logic             pop_en;

    assign empty = (level == '0);
    assign full  = (level == LVL_W'(DEPTH));

    // Guard here as well so the FIFO is safe on its own, not only behind
    // the steering logic in the top.
    assign push_en = push & ~full;
    assign pop_en  = pop & ~empty;

    // Stale entries are masked by 'empty', so storage needs no reset.
    assign head_data = empty ? '0 : mem[rptr];

    always_ff @(posedge clk) begin
        if (push_en)
            mem[wptr] <= push_data;
    end

    // Pointers are log2(DEPTH) bits wide so they wrap without a compare.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push_en)
                wptr <= wptr + PTR_W'(1);
            if (pop_en)
                rptr <= rptr + PTR_W'(1);
            case ({push_en, pop_en})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

endmodule : demux_fifo

// File: rtl/demux2_4.sv
// demux2_4
//   Registered 1-to-2 demultiplexer: each input word is steered by in_sel
//   into channel A (sel=1) or channel B (sel=0), each backed by its own
//   show-ahead FIFO so a stalled consumer on one side never loses data or
//   blocks the other side.
// Ports
//   clk, rst                  rising-edge clock, async active-high reset
//   in_data/in_sel/in_valid   input word, route select, valid
//   in_ready                  selected channel has room (combinational)
//   a_data/a_valid/a_ready    channel A head word handshake
//   b_data/b_valid/b_ready    channel B head word handshake
//   a_level/b_level           per-channel occupancy, 0..DEPTH
import demux_pkg::*;

module demux2_4 #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [WIDTH-1:0]               in_data,
    input  logic                           in_sel,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [WIDTH-1:0]               a_data,
    output logic                           a_valid,
    input  logic                           a_ready,
    output logic [WIDTH-1:0]               b_data,
    output logic                           b_valid,
    input  logic                           b_ready,
    output logic [$clog2(DEPTH+1)-1:0]     a_level,
    output logic [$clog2(DEPTH+1)-1:0]     b_level
);

    logic a_full, a_empty, a_push;
    logic b_full, b_empty, b_push;
    logic sel_a;

    assign sel_a = (in_sel == CH_A);

    // Ready only reflects the selected channel's fullness; a same-cycle pop
    // does not free a slot for the push, keeping this path short.
    assign in_ready = sel_a ? ~a_full : ~b_full;

    assign a_push = in_valid & in_ready &  sel_a;
    assign b_push = in_valid & in_ready & ~sel_a;

    assign a_valid = ~a_empty;
    assign b_valid = ~b_empty;

    demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_a (
        .clk       (clk),
        .rst       (rst),
        .push      (a_push),
        .push_data (in_data),
        .pop       (a_ready),
        .full      (a_full),
        .empty     (a_empty),
        .level     (a_level),
        .head_data (a_data)
    );

    demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_b (
        .clk       (clk),
        .rst       (rst),
        .push      (b_push),
        .push_data (in_data),
        .pop       (b_ready),
        .full      (b_full),
        .empty     (b_empty),
        .level     (b_level),
        .head_data (b_data)
    );

endmodule : demux2_4

// File: tb/tb_demux2_4.sv
module tb_demux2_4;

    logic       clk;
    logic       rst;
    logic [3:0] in_data;
    logic       in_sel;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] a_data;
    logic       a_valid;
    logic       a_ready;
    logic [3:0] b_data;
    logic       b_valid;
    logic       b_ready;
    logic [2:0] a_level;
    logic [2:0] b_level;

    int total = 0;
    int bad   = 0;

    demux2_4 dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_data   (a_data),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .b_data   (b_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .a_level  (a_level),
        .b_level  (b_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge (the drive point).
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        in_data  = 4'($urandom);
        in_sel   = 1'($urandom);
        in_valid = 1'b1;
        a_ready  = 1'($urandom);
        b_ready  = 1'($urandom);
        #2;
        total++;
        if (a_valid !== 1'b0 || b_valid !== 1'b0) begin
            bad++; $display("FAIL reset_valid: got a=%b b=%b want 0 0", a_valid, b_valid);
        end
        total++;
        if (a_data !== 4'h0 || b_data !== 4'h0) begin
            bad++; $display("FAIL reset_data: got a=%h b=%h want 0 0", a_data, b_data);
        end
        total++;
        if (a_level !== 3'd0 || b_level !== 3'd0) begin
            bad++; $display("FAIL reset_level: got a=%0d b=%0d want 0 0", a_level, b_level);
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        a_ready  = 1'b0;
        b_ready  = 1'b0;
        rst      = 1'b0;
        tick();
    endtask

    task automatic test_routing();
        logic [3:0] wd [4];
        logic       ws [4];
        wd[0] = 4'b1111; ws[0] = 1'b1;
        wd[1] = 4'b0000; ws[1] = 1'b0;
        wd[2] = 4'b1110; ws[2] = 1'b1;
        wd[3] = 4'b0001; ws[3] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_data = wd[i]; in_sel = ws[i]; in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        #1;
        total++;
        if (a_level !== 3'd2 || a_data !== 4'b1111) begin
            bad++; $display("FAIL route_a: got lvl=%0d data=%b want 2 1111", a_level, a_data);
        end
        total++;
        if (b_level !== 3'd2 || b_data !== 4'b0000) begin
            bad++; $display("FAIL route_b: got lvl=%0d data=%b want 2 0000", b_level, b_data);
        end
        a_ready = 1'b1;
        tick();
        total++;
        if (a_data !== 4'b1110 || a_level !== 3'd1) begin
            bad++; $display("FAIL route_a_pop1: got data=%b lvl=%0d want 1110 1", a_data, a_level);
        end
        tick();
        a_ready = 1'b0;
        #1;
        total++;
        if (a_valid !== 1'b0 || a_data !== 4'h0) begin
            bad++; $display("FAIL route_a_empty: got valid=%b data=%b want 0 0000", a_valid, a_data);
        end
        b_ready = 1'b1;
        tick();
        total++;
        if (b_data !== 4'b0001 || b_level !== 3'd1) begin
            bad++; $display("FAIL route_b_pop1: got data=%b lvl=%0d want 0001 1", b_data, b_level);
        end
        tick();
        b_ready = 1'b0;
        #1;
        total++;
        if (b_valid !== 1'b0 || b_level !== 3'd0) begin
            bad++; $display("FAIL route_b_empty: got valid=%b lvl=%0d want 0 0", b_valid, b_level);
        end
        tick();
    endtask

    task automatic test_full_backpressure();
        logic [3:0] exp_b [4];
        exp_b[0] = 4'b1001; exp_b[1] = 4'b1010; exp_b[2] = 4'b1011; exp_b[3] = 4'b0111;
        for (int i = 0; i < 4; i++) begin
            in_data = 4'(8 + i); in_sel = 1'b0; in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        #1;
        total++;
        if (b_level !== 3'd4 || in_ready !== 1'b0) begin
            bad++; $display("FAIL full_b: got lvl=%0d in_ready=%b want 4 0", b_level, in_ready);
        end
        in_sel = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++; $display("FAIL full_sel_a_ready: got %b want 1", in_ready);
        end
        in_data = 4'b0110; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        #1;
        total++;
        if (a_level !== 3'd1 || a_data !== 4'b0110 || b_level !== 3'd4) begin
            bad++; $display("FAIL full_push_a: got alvl=%0d adata=%b blvl=%0d want 1 0110 4",
                            a_level, a_data, b_level);
        end
        a_ready = 1'b1;
        tick();
        a_ready = 1'b0;
        // Push to full B while it is being popped: must be refused.
        in_sel = 1'b0; in_data = 4'b0111; in_valid = 1'b1; b_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b0) begin
            bad++; $display("FAIL full_pop_refuse_ready: got %b want 0", in_ready);
        end
        tick();
        b_ready = 1'b0;
        #1;
        total++;
        if (b_level !== 3'd3 || b_data !== 4'b1001 || in_ready !== 1'b1) begin
            bad++; $display("FAIL full_after_pop: got lvl=%0d data=%b rdy=%b want 3 1001 1",
                            b_level, b_data, in_ready);
        end
        tick();
        in_valid = 1'b0;
        #1;
        total++;
        if (b_level !== 3'd4) begin
            bad++; $display("FAIL full_retry_push: got lvl=%0d want 4", b_level);
        end
        b_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (b_valid !== 1'b1 || b_data !== exp_b[i]) begin
                bad++; $display("FAIL full_drain_%0d: got valid=%b data=%b want 1 %b",
                                i, b_valid, b_data, exp_b[i]);
            end
            tick();
        end
        b_ready = 1'b0;
        #1;
        total++;
        if (b_valid !== 1'b0 || a_valid !== 1'b0) begin
            bad++; $display("FAIL full_drained: got b=%b a=%b want 0 0", b_valid, a_valid);
        end
        tick();
    endtask

    task automatic test_simul_push_pop();
        in_sel = 1'b0; in_valid = 1'b1;
        in_data = 4'b0010; tick();
        in_data = 4'b0011; tick();
        b_ready = 1'b1;
        // Each cycle pushes 4+i and pops the head, which is expected to be 2+i.
        for (int i = 0; i < 6; i++) begin
            in_data = 4'(4 + i);
            #1;
            total++;
            if (b_data !== 4'(2 + i) || in_ready !== 1'b1) begin
                bad++; $display("FAIL simul_head_%0d: got data=%b rdy=%b want %b 1",
                                i, b_data, in_ready, 4'(2 + i));
            end
            tick();
            total++;
            if (b_level !== 3'd2) begin
                bad++; $display("FAIL simul_level_%0d: got %0d want 2", i, b_level);
            end
        end
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            total++;
            if (b_data !== 4'(8 + i)) begin
                bad++; $display("FAIL simul_tail_%0d: got %b want %b", i, b_data, 4'(8 + i));
            end
            tick();
        end
        b_ready = 1'b0;
        #1;
        total++;
        if (b_level !== 3'd0) begin
            bad++; $display("FAIL simul_empty: got %0d want 0", b_level);
        end
        tick();
    endtask

    task automatic test_wrap();
        int pushed = 0;
        int popped = 0;
        int cyc    = 0;
        in_sel = 1'b1;
        while (popped < 10 && cyc < 30) begin
            in_valid = (pushed < 10);
            in_data  = 4'(13 - pushed);
            a_ready  = (cyc >= 2) && (popped < pushed);
            #1;
            total++;
            if (a_level !== 3'(pushed - popped) || a_valid !== (pushed > popped)) begin
                bad++; $display("FAIL wrap_level_c%0d: got lvl=%0d valid=%b want %0d %b",
                                cyc, a_level, a_valid, pushed - popped, pushed > popped);
            end
            if (a_ready) begin
                total++;
                if (a_data !== 4'(13 - popped)) begin
                    bad++; $display("FAIL wrap_data_%0d: got %b want %b",
                                    popped, a_data, 4'(13 - popped));
                end
                popped++;
            end
            if (in_valid) pushed++;
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        a_ready  = 1'b0;
        total++;
        if (popped != 10) begin
            bad++; $display("FAIL wrap_timeout: got popped=%0d want 10", popped);
        end
        #1;
        total++;
        if (a_valid !== 1'b0) begin
            bad++; $display("FAIL wrap_empty: got %b want 0", a_valid);
        end
        tick();
    endtask

    task automatic test_async_reset();
        in_sel = 1'b1; in_valid = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            in_data = 4'(i);
            tick();
        end
        in_valid = 1'b0;
        #1;
        total++;
        if (a_level !== 3'd3 || a_data !== 4'b0001) begin
            bad++; $display("FAIL arst_pre: got lvl=%0d data=%b want 3 0001", a_level, a_data);
        end
        #1;
        rst = 1'b1;   // mid-cycle, no clock edge until later
        #1;
        total++;
        if (a_valid !== 1'b0 || a_level !== 3'd0 || a_data !== 4'h0) begin
            bad++; $display("FAIL arst_immediate: got valid=%b lvl=%0d data=%b want 0 0 0000",
                            a_valid, a_level, a_data);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        in_data = 4'b1010; in_sel = 1'b1; in_valid = 1'b1;
        #1;
        total++;
        if (a_valid !== 1'b0 || a_level !== 3'd0) begin
            bad++; $display("FAIL arst_no_bypass: got valid=%b lvl=%0d want 0 0", a_valid, a_level);
        end
        tick();
        in_valid = 1'b0;
        #1;
        total++;
        if (a_valid !== 1'b1 || a_data !== 4'b1010 || a_level !== 3'd1) begin
            bad++; $display("FAIL arst_first_push: got valid=%b data=%b lvl=%0d want 1 1010 1",
                            a_valid, a_data, a_level);
        end
        a_ready = 1'b1;
        tick();
        a_ready = 1'b0;
        #1;
        total++;
        if (a_valid !== 1'b0) begin
            bad++; $display("FAIL arst_final_pop: got %b want 0", a_valid);
        end
    endtask

    initial begin
        test_reset();
        test_routing();
        test_full_backpressure();
        test_simul_push_pop();
        test_wrap();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_demux2_4
